// File: rtl/delay_line_pkg.sv
// Shared types and defaults for the delay-line pulse measurement blocks.
// Sequencer states, parameter defaults and the per-pulse result record.
package delay_line_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;
  localparam int TIMEOUT_DEF = 1000;
  localparam int HOLDOFF_DEF = 50;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT,
    REPORT,
    GAP,
    DONE
  } pseq_state_t;

  typedef struct packed {
    logic                 timeout;
    logic [CNT_W_DEF-1:0] data;
  } meas_t;

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Result channel of the pulse sequencer: one echo measurement per transfer.
// The producer drives data/timeout/valid, the consumer drives ready.
interface pulse_seq_ctrl_if
  import delay_line_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [CNT_W-1:0] meas_data;
  logic             meas_timeout;
  logic             meas_valid;
  logic             meas_ready;

  modport master (
    output meas_data,
    output meas_timeout,
    output meas_valid,
    input  meas_ready
  );

  modport slave (
    input  meas_data,
    input  meas_timeout,
    input  meas_valid,
    output meas_ready
  );

endinterface

// File: rtl/rise_detect.sv
// Single-register rising-edge detector for a clk-synchronous echo line.
// The history register always tracks the input; only the output is gated by arm.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic sig,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // next history value is simply the current input
  always_comb begin
    prev_d = sig;
  end

  // previous-cycle copy of the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = arm & sig & ~prev_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Burst sequencer: fires trigger strobes, times each echo, reports results.
// All outputs come straight from flops; states follow the delay-line enum.
module pulse_seq_ctrl
  import delay_line_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BURST_W-1:0] n_pulses,
  output logic               pulse_en,
  input  logic               echo,
  output logic               busy,
  output logic               done,
  pulse_seq_ctrl_if.master   meas
);

  localparam int GAP_W = $clog2(HOLDOFF + 1);

  pseq_state_t        state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tmo_q, tmo_d;
  logic               valid_q, valid_d;
  logic               pe_q, pe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               arm;
  logic               rise;

  assign arm = (state_q == WAIT);

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .arm  (arm),
    .sig  (echo),
    .rise (rise)
  );

  // next state, counters, held result and registered output values
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    valid_d = valid_q;
    gap_d   = gap_q;
    cnt_inc = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = n_pulses;
          state_d = (n_pulses == '0) ? DONE : FIRE;
        end
      end
      FIRE: begin
        rem_d   = rem_q - 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (rise) begin
          data_d  = cnt_inc;
          tmo_d   = 1'b0;
          valid_d = 1'b1;
          state_d = REPORT;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          data_d  = CNT_W'(TIMEOUT);
          tmo_d   = 1'b1;
          valid_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (meas.meas_ready) begin
          valid_d = 1'b0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(HOLDOFF - 1)) begin
          state_d = (rem_q != '0) ? FIRE : DONE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pe_d   = (state_d == FIRE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // state and output registers; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      gap_q   <= '0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_en          = pe_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign meas.meas_data    = data_q;
  assign meas.meas_timeout = tmo_q;
  assign meas.meas_valid   = valid_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl: vector table, corner sequences,
// and random bursts compared against a latency/timeout reference model.
module tb_pulse_seq_ctrl;
  import delay_line_pkg::*;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;
  localparam int TIMEOUT = 1000;
  localparam int HOLDOFF = 50;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [BURST_W-1:0] n_pulses = '0;
  logic               pulse_en;
  logic               busy;
  logic               done;
  logic               echo_r = 1'b0;
  logic               echo_hi = 1'b0;
  logic               echo_w;

  assign echo_w = echo_r | echo_hi;

  pulse_seq_ctrl_if #(.CNT_W(CNT_W)) mif ();

  pulse_seq_ctrl #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W),
    .TIMEOUT (TIMEOUT),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_pulses (n_pulses),
    .pulse_en (pulse_en),
    .echo     (echo_w),
    .busy     (busy),
    .done     (done),
    .meas     (mif)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int tot_n = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;
  int last_hs = -1;
  int ready_mode = 0;
  int vcnt = 0;
  int delay_q[$];
  meas_t exp_q[$];
  meas_t mon_e;
  bit prev_pe = 1'b0;
  bit prev_hs = 1'b0;
  bit prev_stall = 1'b0;
  logic [CNT_W-1:0] prev_data = '0;
  logic prev_tmo = 1'b0;
  int resp_d;

  typedef struct {
    int n;
    int d0, d1, d2;
    int mode;
    int x0, x1, x2;
    bit t0, t1, t2;
    int poke;
  } vec_t;

  vec_t tab[10];
  int   rn, rd, pk;
  meas_t rm;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    tot_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic meas_t ref_meas(input int d);
    meas_t m;
    if (d >= 1 && d <= TIMEOUT) begin
      m.timeout = 1'b0;
      m.data    = CNT_W'(d);
    end else begin
      m.timeout = 1'b1;
      m.data    = CNT_W'(TIMEOUT);
    end
    return m;
  endfunction

  task automatic push_pulse(input int d, input int xd, input bit xt);
    meas_t m;
    m.data    = CNT_W'(xd);
    m.timeout = xt;
    delay_q.push_back(d);
    exp_q.push_back(m);
  endtask

  // echo source: rise d cycles after each strobe (0 = lost)
  always @(negedge clk) begin
    if (!rst && pulse_en) begin
      if (delay_q.size() > 0) resp_d = delay_q.pop_front();
      else resp_d = 0;
      if (resp_d > 0) begin
        repeat (resp_d) @(posedge clk);
        #1 echo_r = 1'b1;
        repeat (2) @(posedge clk);
        #1 echo_r = 1'b0;
      end
    end
  end

  // consumer ready: always, random, or 40-cycle stall per result
  always @(posedge clk) begin
    #1;
    if (mif.meas_valid) vcnt++;
    else vcnt = 0;
    if (ready_mode == 0) mif.meas_ready = 1'b1;
    else if (ready_mode == 1) mif.meas_ready = 1'($urandom_range(0, 1));
    else mif.meas_ready = (vcnt > 40);
  end

  // monitor: strobes, spacing, handshake stability, result scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_pe    = 1'b0;
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pulse_en) begin
        pulse_cnt++;
        chk(!prev_pe, "pulse_width", prev_pe, 0);
        chk(!mif.meas_valid, "pulse_while_pending", mif.meas_valid, 0);
        if (last_hs >= 0)
          chk(cyc == last_hs + HOLDOFF + 1, "pulse_spacing",
              cyc - last_hs, HOLDOFF + 1);
      end
      if (done) begin
        done_cnt++;
        if (last_hs >= 0)
          chk(cyc == last_hs + HOLDOFF + 1, "done_spacing",
              cyc - last_hs, HOLDOFF + 1);
      end
      if (prev_hs)
        chk(!mif.meas_valid, "valid_drop", mif.meas_valid, 0);
      if (prev_stall)
        chk(mif.meas_valid && mif.meas_data == prev_data &&
            mif.meas_timeout == prev_tmo, "hold_stable",
            mif.meas_data, prev_data);
      prev_hs    = mif.meas_valid && mif.meas_ready;
      prev_stall = mif.meas_valid && !mif.meas_ready;
      prev_data  = mif.meas_data;
      prev_tmo   = mif.meas_timeout;
      prev_pe    = pulse_en;
      if (prev_hs) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_result", mif.meas_data, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk(mif.meas_data == mon_e.data, "meas_data",
              mif.meas_data, mon_e.data);
          chk(mif.meas_timeout == mon_e.timeout, "meas_timeout",
              mif.meas_timeout, mon_e.timeout);
        end
        last_hs = cyc;
      end
    end
  end

  task automatic run_burst(input int n, input int poke);
    int p0, d0;
    bit got;
    p0 = pulse_cnt;
    d0 = done_cnt;
    last_hs = -1;
    @(posedge clk);
    #1 start = 1'b1;
    n_pulses = BURST_W'(n);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    if (n > 0) chk(pulse_en, "fire_latency", pulse_en, 1);
    else chk(done && !pulse_en, "zero_done", done, 1);
    chk(busy, "busy_set", busy, 1);
    got = (n == 0) && done;
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 8000 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk(got, "done_seen", got, 1);
    @(negedge clk);
    chk(!busy, "busy_clear", busy, 0);
    chk(pulse_cnt - p0 == n, "pulse_count", pulse_cnt - p0, n);
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(exp_q.size() == 0, "results_left", exp_q.size(), 0);
    exp_q.delete();
    delay_q.delete();
  endtask

  initial begin
    tab[0] = '{1,    7,  0,  0, 0,    7,  0,  0, 1'b0, 1'b0, 1'b0,  0};
    tab[1] = '{3,    5, 12, 30, 0,    5, 12, 30, 1'b0, 1'b0, 1'b0,  0};
    tab[2] = '{1,    0,  0,  0, 0, 1000,  0,  0, 1'b1, 1'b0, 1'b0,  0};
    tab[3] = '{1,    1,  0,  0, 0,    1,  0,  0, 1'b0, 1'b0, 1'b0,  0};
    tab[4] = '{1, 1000,  0,  0, 0, 1000,  0,  0, 1'b0, 1'b0, 1'b0,  0};
    tab[5] = '{1, 1005,  0,  0, 0, 1000,  0,  0, 1'b1, 1'b0, 1'b0,  0};
    tab[6] = '{2,   20,  9,  0, 2,   20,  9,  0, 1'b0, 1'b0, 1'b0,  0};
    tab[7] = '{0,    0,  0,  0, 0,    0,  0,  0, 1'b0, 1'b0, 1'b0,  0};
    tab[8] = '{1,   30,  0,  0, 0,   30,  0,  0, 1'b0, 1'b0, 1'b0, 10};
    tab[9] = '{3,    3,  4, 60, 1,    3,  4, 60, 1'b0, 1'b0, 1'b0,  0};

    repeat (3) @(negedge clk);
    chk(!pulse_en && !busy && !done, "reset_ctrl",
        {pulse_en, busy, done}, 0);
    chk(!mif.meas_valid && !mif.meas_timeout && mif.meas_data == '0,
        "reset_meas", mif.meas_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      ready_mode = tab[i].mode;
      for (int k = 0; k < tab[i].n; k++) begin
        if (k == 0) push_pulse(tab[i].d0, tab[i].x0, tab[i].t0);
        else if (k == 1) push_pulse(tab[i].d1, tab[i].x1, tab[i].t1);
        else push_pulse(tab[i].d2, tab[i].x2, tab[i].t2);
      end
      run_burst(tab[i].n, tab[i].poke);
      if (tab[i].poke > 0) begin
        pk = pulse_cnt;
        repeat (60) @(negedge clk);
        chk(pulse_cnt == pk && !busy, "no_restart", pulse_cnt - pk, 0);
      end
    end

    ready_mode = 0;
    echo_hi = 1'b1;
    push_pulse(0, TIMEOUT, 1'b1);
    run_burst(1, 0);
    echo_hi = 1'b0;

    exp_q.delete();
    delay_q.delete();
    last_hs = -1;
    @(posedge clk);
    #1 start = 1'b1;
    n_pulses = BURST_W'(3);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk(busy, "busy_in_wait", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk(!busy, "async_busy", busy, 0);
    chk(!pulse_en && !done && !mif.meas_valid && !mif.meas_timeout &&
        mif.meas_data == '0, "async_outputs", mif.meas_data, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    pk = pulse_cnt;
    repeat (60) @(negedge clk);
    chk(!busy && pulse_cnt == pk, "no_resume", pulse_cnt - pk, 0);
    push_pulse(7, 7, 1'b0);
    run_burst(1, 0);

    for (int r = 0; r < 6; r++) begin
      rn = $urandom_range(1, 3);
      ready_mode = $urandom_range(0, 2);
      for (int k = 0; k < rn; k++) begin
        if ($urandom_range(0, 9) == 0) rd = 0;
        else rd = $urandom_range(1, 80);
        rm = ref_meas(rd);
        push_pulse(rd, int'(rm.data), rm.timeout);
      end
      run_burst(rn, 0);
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/pulse_seq_ctrl.md
Name: pulse_seq_ctrl

Overview:
- Sequencer for the delay-line pulse generator.
- On `start`, fires a programmable burst of single-cycle trigger strobes into the generator's enable input, spaced by a fixed hold-off.
- After each strobe, times the returning echo edge with a cycle counter and reports one result per pulse over a valid/ready handshake.
- Sits between the host/register interface and the pulse generator plus echo comparator.

Parameters:
- CNT_W, 16, width of the echo-latency counter and result.
- BURST_W, 8, width of the pulse-count request.
- TIMEOUT, 1000, WAIT cycles before a pulse is declared lost; must be < 2**CNT_W.
- HOLDOFF, 50, idle cycles after each result is accepted, before the next strobe; must be ≥ 1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- n_pulses  in  BURST_W  pulses in burst; captured on accepted start.
- pulse_en  out  1  trigger to pulse generator enable; one-cycle strobe.
- echo  in  1  delay-line return, already synchronous to clk.
- meas_data  out  CNT_W  echo latency in cycles, or TIMEOUT on loss.
- meas_timeout  out  1  qualifies meas_data as a lost pulse.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle strobe at burst end.

Behaviour:
- Reset: asynchronous, active-high, fixed by design; clock port `clk`, reset port `rst`.
  - Asserting rst at any time forces IDLE immediately.
  - pulse_en=0, meas_valid=0, meas_timeout=0, meas_data=0, busy=0, done=0; counters cleared.
  - A burst interrupted by reset is abandoned, not resumed.
- All outputs registered.
- States: IDLE, FIRE, WAIT, REPORT, GAP, DONE.
- IDLE:
  - start=1 latches n_pulses into `remaining`.
  - If n_pulses==0, go to DONE: no strobe; done high the next cycle.
  - Otherwise go to FIRE.
- FIRE (exactly 1 cycle):
  - pulse_en=1.
  - Latency: pulse_en is high in the cycle after the edge that sampled start=1.
  - Decrement `remaining`; clear the latency counter; go to WAIT.
- WAIT:
  - Counter increments each cycle from 1.
  - Rise detect: echo=1 with previous-cycle echo=0; the detector is armed only in WAIT, so edges in FIRE/GAP are ignored.
  - On a rise: meas_data = counter value, meas_timeout=0, go to REPORT.
  - Echo rise sampled on the first WAIT edge gives meas_data=1.
  - If the counter reaches TIMEOUT with no rise: meas_data=TIMEOUT, meas_timeout=1, go to REPORT.
  - A rise on the same edge as the timeout takes priority and is reported as a valid latency of TIMEOUT.
  - Echo already high on entry to WAIT is not a rise.
- REPORT:
  - meas_valid=1; meas_data and meas_timeout held stable until meas_valid & meas_ready.
  - Transfer occurs on a clock edge with both high; meas_valid drops the next cycle.
  - meas_ready ignored when meas_valid=0.
  - Backpressure is unbounded; no pulse fires while a result is pending.
- GAP:
  - Exactly HOLDOFF cycles, pulse_en=0.
  - Then go to FIRE if remaining≠0, else DONE.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored; it is not queued.
- Counter saturation cannot occur, given the TIMEOUT < 2**CNT_W constraint.

Decomposition:
- Shared package `delay_line_pkg`:
  - state enum `pseq_state_t`.
  - default constants for CNT_W, BURST_W, TIMEOUT, HOLDOFF.
  - result struct {timeout, data}.
- One natural sub-module, `rise_detect`:
  - one-register echo edge detector with an arm input.
  - reusable by other delay-line measurement blocks.

Test Plan:
- Single pulse, echo rise 7 cycles after pulse_en: n_pulses=1, start, meas_ready=1 -> pulse_en high 1 cycle; meas_data=7, meas_timeout=0; done 1 cycle after the 50-cycle GAP; busy low after.
- Burst of 3, echo delays 5/12/30: -> three results 5, 12, 30 in order; strobes spaced by result handshake + 50 cycles; exactly 3 pulse_en strobes.
- Lost echo, TIMEOUT=1000, echo held low -> meas_data=1000, meas_timeout=1; sequence continues to GAP/DONE.
- Backpressure, meas_ready=0 for 40 cycles in REPORT -> meas_valid and meas_data stable for all 40 cycles; no pulse_en; accepted on first ready cycle; valid drops the cycle after.
- n_pulses=0, and start pulsed again while busy -> zero-pulse burst gives done with no pulse_en; start during WAIT does not extend or restart the burst.
- Async rst asserted mid-WAIT between clock edges -> outputs zero immediately (before the next edge); after release, IDLE with busy=0; a fresh start operates normally.
